gt_victim_buffer: RTL and testbench

GT_VICTIM_BUFFER -- requirements
Module: gt_victim_buffer

---
 rtl/gt_victim_buffer.sv | 188 ++++++++++++++++++
 tb/tb_gt_victim_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gt_victim_buffer.sv
// Fully-associative victim buffer between L1 and memory: catches L1 evictions, serves swap-back lookups.
// Latency: lookup result registered, one cycle after request; insert accepted in the request cycle.
// Backpressure: insert_ready drops while a dirty victim waits in the writeback register for wb_ready.
module gt_victim_buffer #(
   parameter int ADDR_W   = 32,
   parameter int LINE_W   = 256,
   parameter int OFFSET_W = 5,
   parameter int ENTRIES  = 4
) (
   input  logic                           CLK,
   input  logic                           RST_N,
   input  logic                           lookup_valid,
   input  logic [ADDR_W-1:0]              lookup_addr,
   output logic                           lookup_hit,
   output logic [LINE_W-1:0]              lookup_data,
   output logic                           lookup_dirty,
   input  logic                           insert_valid,
   output logic                           insert_ready,
   input  logic [ADDR_W-1:0]              insert_addr,
   input  logic [LINE_W-1:0]              insert_data,
   input  logic                           insert_dirty,
   output logic                           wb_valid,
   input  logic                           wb_ready,
   output logic [ADDR_W-1:0]              wb_addr,
   output logic [LINE_W-1:0]              wb_data,
   output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);
   localparam int TAG_W = ADDR_W - OFFSET_W;
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int OCC_W = $clog2(ENTRIES+1);

   typedef enum logic {S_IDLE, S_WB} state_t;

   state_t                   state_q, state_d;
   logic [ENTRIES-1:0]       valid_q, valid_d;
   logic [ENTRIES-1:0]       dirty_q, dirty_d;
   logic [TAG_W-1:0]         tag_q  [ENTRIES];
   logic [TAG_W-1:0]         tag_d  [ENTRIES];
   logic [LINE_W-1:0]        data_q [ENTRIES];
   logic [LINE_W-1:0]        data_d [ENTRIES];
   logic [IDX_W-1:0]         ptr_q, ptr_d;
   logic [ADDR_W-1:0]        wb_addr_q, wb_addr_d;
   logic [LINE_W-1:0]        wb_data_q, wb_data_d;
   logic                     hit_q, hit_d;
   logic [LINE_W-1:0]        ldata_q, ldata_d;
   logic                     ldirty_q, ldirty_d;

   logic [TAG_W-1:0]         tag_lk, tag_in;
   logic                     lk_any, ins_match, free_any, ins_fire;
   logic [IDX_W-1:0]         lk_idx, match_idx, free_idx;
   logic [OCC_W-1:0]         occ;
   logic                     unused_offset;

   // Offset bits only select bytes inside a line; the buffer tracks whole lines.
   assign unused_offset = ^{lookup_addr[OFFSET_W-1:0], insert_addr[OFFSET_W-1:0]};

   assign tag_lk   = lookup_addr[ADDR_W-1:OFFSET_W];
   assign tag_in   = insert_addr[ADDR_W-1:OFFSET_W];
   assign ins_fire = insert_valid && (state_q == S_IDLE);

   // Tag search over pre-update contents: lookup hit, insert tag match, lowest free slot, occupancy.
   always_comb begin
      lk_any    = 1'b0;
      lk_idx    = '0;
      ins_match = 1'b0;
      match_idx = '0;
      free_any  = 1'b0;
      free_idx  = '0;
      occ       = '0;
      for (int i = ENTRIES-1; i >= 0; i--) begin
         if (valid_q[i] && tag_q[i] == tag_lk) begin
            lk_any = 1'b1;
            lk_idx = IDX_W'(i);
         end
         if (valid_q[i] && tag_q[i] == tag_in) begin
            ins_match = 1'b1;
            match_idx = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
         if (valid_q[i]) occ = occ + OCC_W'(1);
      end
   end

   // Next state for entries, FIFO pointer, writeback register and lookup result; FSM transitions too.
   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      tag_d     = tag_q;
      data_d    = data_q;
      ptr_d     = ptr_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      hit_d     = 1'b0;
      ldata_d   = '0;
      ldirty_d  = 1'b0;

      // Exclusive swap: a hit hands the line back to L1 and frees the entry.
      if (lookup_valid) begin
         if (lk_any) begin
            hit_d           = 1'b1;
            ldata_d         = data_q[lk_idx];
            ldirty_d        = dirty_q[lk_idx];
            valid_d[lk_idx] = 1'b0;
         end else if (state_q == S_WB && wb_addr_q[ADDR_W-1:OFFSET_W] == tag_lk) begin
            // Line still leaving for memory: L1 gets a clean copy, writeback continues.
            hit_d   = 1'b1;
            ldata_d = wb_data_q;
         end
      end

      if (state_q == S_WB && wb_ready) state_d = S_IDLE;

      // Insert is written after the lookup invalidation so a same-tag insert leaves the entry valid.
      if (ins_fire) begin
         if (ins_match) begin
            valid_d[match_idx] = 1'b1;
            dirty_d[match_idx] = dirty_q[match_idx] | insert_dirty;
            data_d[match_idx]  = insert_data;
         end else if (free_any) begin
            valid_d[free_idx] = 1'b1;
            dirty_d[free_idx] = insert_dirty;
            tag_d[free_idx]   = tag_in;
            data_d[free_idx]  = insert_data;
         end else begin
            if (dirty_q[ptr_q]) begin
               wb_addr_d = {tag_q[ptr_q], {OFFSET_W{1'b0}}};
               wb_data_d = data_q[ptr_q];
               state_d   = S_WB;
            end
            valid_d[ptr_q] = 1'b1;
            dirty_d[ptr_q] = insert_dirty;
            tag_d[ptr_q]   = tag_in;
            data_d[ptr_q]  = insert_data;
            ptr_d          = ptr_q + IDX_W'(1);
         end
      end
   end

   // FSM state register; reset abandons any pending writeback.
   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Datapath registers: entry array, pointer, writeback line, lookup result.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         valid_q   <= '0;
         dirty_q   <= '0;
         ptr_q     <= '0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         hit_q     <= 1'b0;
         ldata_q   <= '0;
         ldirty_q  <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q   <= valid_d;
         dirty_q   <= dirty_d;
         ptr_q     <= ptr_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         hit_q     <= hit_d;
         ldata_q   <= ldata_d;
         ldirty_q  <= ldirty_d;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]  <= tag_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   assign lookup_hit   = hit_q;
   assign lookup_data  = ldata_q;
   assign lookup_dirty = ldirty_q;
   assign insert_ready = (state_q == S_IDLE);
   assign wb_valid     = (state_q == S_WB);
   assign wb_addr      = wb_addr_q;
   assign wb_data      = wb_data_q;
   assign occupancy    = occ;
endmodule

// File: tb/tb_gt_victim_buffer.sv
// Directed bench for gt_victim_buffer with hand-computed expectations.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// Covers reset, swap-back, clean/dirty eviction, writeback stall, WB-register hits, same-cycle lookup/insert.
module tb_gt_victim_buffer;
   logic          CLK = 1'b0;
   logic          RST_N;
   logic          lookup_valid;
   logic [31:0]   lookup_addr;
   logic          lookup_hit;
   logic [255:0]  lookup_data;
   logic          lookup_dirty;
   logic          insert_valid;
   logic          insert_ready;
   logic [31:0]   insert_addr;
   logic [255:0]  insert_data;
   logic          insert_dirty;
   logic          wb_valid;
   logic          wb_ready;
   logic [31:0]   wb_addr;
   logic [255:0]  wb_data;
   logic [2:0]    occupancy;

   int checks   = 0;
   int failures = 0;

   gt_victim_buffer dut (
      .CLK(CLK), .RST_N(RST_N),
      .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
      .lookup_hit(lookup_hit), .lookup_data(lookup_data), .lookup_dirty(lookup_dirty),
      .insert_valid(insert_valid), .insert_ready(insert_ready), .insert_addr(insert_addr),
      .insert_data(insert_data), .insert_dirty(insert_dirty),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .occupancy(occupancy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] pat(input logic [7:0] b);
      return {32{b}};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST_N        = 1'b0;
      lookup_valid = 1'b0;
      lookup_addr  = '0;
      insert_valid = 1'b0;
      insert_addr  = '0;
      insert_data  = '0;
      insert_dirty = 1'b0;
      wb_ready     = 1'b0;
      tick();
      tick();
      RST_N = 1'b1;
   endtask

   task automatic do_insert(input logic [31:0] a, input logic [7:0] b, input logic d);
      insert_valid = 1'b1;
      insert_addr  = a;
      insert_data  = pat(b);
      insert_dirty = d;
      tick();
      insert_valid = 1'b0;
   endtask

   task automatic do_lookup(input logic [31:0] a);
      lookup_valid = 1'b1;
      lookup_addr  = a;
      tick();
      lookup_valid = 1'b0;
   endtask

   task automatic fill_dirty();
      do_insert(32'h000, 8'hE0, 1'b1);
      do_insert(32'h020, 8'hE1, 1'b1);
      do_insert(32'h040, 8'hE2, 1'b1);
      do_insert(32'h060, 8'hE3, 1'b1);
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_hit", 256'(lookup_hit), 256'(0));
      chk("rst_data", lookup_data, '0);
      chk("rst_dirty", 256'(lookup_dirty), 256'(0));
      chk("rst_wbv", 256'(wb_valid), 256'(0));
      chk("rst_wbaddr", 256'(wb_addr), 256'(0));
      chk("rst_wbdata", wb_data, '0);
      chk("rst_occ", 256'(occupancy), 256'(0));
      chk("rst_ready", 256'(insert_ready), 256'(1));

      // Single clean insert then swap-back with offset bits set
      do_insert(32'h020, 8'hAA, 1'b0);
      chk("t1_occ1", 256'(occupancy), 256'(1));
      do_lookup(32'h03F);
      chk("t1_hit", 256'(lookup_hit), 256'(1));
      chk("t1_data", lookup_data, pat(8'hAA));
      chk("t1_dirty", 256'(lookup_dirty), 256'(0));
      chk("t1_occ0", 256'(occupancy), 256'(0));

      // Clean FIFO eviction is silent
      do_reset();
      do_insert(32'h000, 8'hD0, 1'b0);
      do_insert(32'h020, 8'hD1, 1'b0);
      do_insert(32'h040, 8'hD2, 1'b0);
      do_insert(32'h060, 8'hD3, 1'b0);
      chk("t2_full", 256'(occupancy), 256'(4));
      do_insert(32'h080, 8'hD4, 1'b0);
      chk("t2_nowb", 256'(wb_valid), 256'(0));
      chk("t2_occ", 256'(occupancy), 256'(4));
      chk("t2_ready", 256'(insert_ready), 256'(1));
      do_lookup(32'h000);
      chk("t2_miss", 256'(lookup_hit), 256'(0));
      chk("t2_missdata", lookup_data, '0);
      do_lookup(32'h080);
      chk("t2_newhit", 256'(lookup_hit), 256'(1));
      chk("t2_newdata", lookup_data, pat(8'hD4));

      // Dirty eviction stalls inserts until the writeback drains
      do_reset();
      fill_dirty();
      wb_ready = 1'b0;
      do_insert(32'h080, 8'hE4, 1'b1);
      chk("t3_wbv", 256'(wb_valid), 256'(1));
      chk("t3_wbaddr", 256'(wb_addr), 256'(32'h000));
      chk("t3_wbdata", wb_data, pat(8'hE0));
      chk("t3_ready0", 256'(insert_ready), 256'(0));
      chk("t3_occ", 256'(occupancy), 256'(4));
      tick();
      chk("t3_hold_wbv", 256'(wb_valid), 256'(1));
      chk("t3_hold_addr", 256'(wb_addr), 256'(32'h000));
      chk("t3_hold_ready", 256'(insert_ready), 256'(0));

      // Lookup hits the line sitting in the writeback register
      do_lookup(32'h000);
      chk("t4_hit", 256'(lookup_hit), 256'(1));
      chk("t4_data", lookup_data, pat(8'hE0));
      chk("t4_dirty", 256'(lookup_dirty), 256'(0));
      chk("t4_wbv", 256'(wb_valid), 256'(1));
      chk("t4_wbdata", wb_data, pat(8'hE0));
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("t4_drained", 256'(wb_valid), 256'(0));
      chk("t4_ready1", 256'(insert_ready), 256'(1));
      do_lookup(32'h000);
      chk("t4_idle_miss", 256'(lookup_hit), 256'(0));

      // Matching-tag overwrite keeps dirty and causes no writeback
      // Entries now: 0x080 E4 d, 0x020 E1 d, 0x040 E2 d, 0x060 E3 d
      do_insert(32'h020, 8'hF1, 1'b0);
      chk("t5_nowb", 256'(wb_valid), 256'(0));
      chk("t5_occ", 256'(occupancy), 256'(4));
      do_lookup(32'h020);
      chk("t5_hit", 256'(lookup_hit), 256'(1));
      chk("t5_data", lookup_data, pat(8'hF1));
      chk("t5_dirty", 256'(lookup_dirty), 256'(1));
      chk("t5_occ3", 256'(occupancy), 256'(3));

      // Same-cycle lookup and insert of the same tag
      lookup_valid = 1'b1;
      lookup_addr  = 32'h040;
      do_insert(32'h040, 8'hB0, 1'b0);
      lookup_valid = 1'b0;
      chk("t6_hit", 256'(lookup_hit), 256'(1));
      chk("t6_olddata", lookup_data, pat(8'hE2));
      chk("t6_occ", 256'(occupancy), 256'(3));
      do_lookup(32'h040);
      chk("t6_newhit", 256'(lookup_hit), 256'(1));
      chk("t6_newdata", lookup_data, pat(8'hB0));
      chk("t6_newdirty", 256'(lookup_dirty), 256'(1));
      chk("t6_occ2", 256'(occupancy), 256'(2));

      // Same-cycle hit on one entry and insert into another free slot
      lookup_valid = 1'b1;
      lookup_addr  = 32'h060;
      do_insert(32'h0A0, 8'hC5, 1'b0);
      lookup_valid = 1'b0;
      chk("t7_hit", 256'(lookup_hit), 256'(1));
      chk("t7_data", lookup_data, pat(8'hE3));
      chk("t7_occ", 256'(occupancy), 256'(2));
      do_lookup(32'h0A0);
      chk("t7_newhit", 256'(lookup_hit), 256'(1));
      chk("t7_newdata", lookup_data, pat(8'hC5));
      chk("t7_newdirty", 256'(lookup_dirty), 256'(0));
      chk("t7_occ1", 256'(occupancy), 256'(1));

      // Reset while a writeback is pending
      do_reset();
      fill_dirty();
      do_insert(32'h080, 8'hE4, 1'b1);
      chk("t8_wbv", 256'(wb_valid), 256'(1));
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      chk("t8_wbv0", 256'(wb_valid), 256'(0));
      chk("t8_occ", 256'(occupancy), 256'(0));
      chk("t8_ready", 256'(insert_ready), 256'(1));
      chk("t8_wbaddr", 256'(wb_addr), 256'(0));
      tick();
      tick();
      chk("t8_stay0", 256'(wb_valid), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
